// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl
//   Sweeps candidate values over a programmed range [lo, hi], one per cycle,
//   feeding a combinational 4-bit prime detector and sampling its result.
//   Each prime found is offered on a valid/ready stream and counted.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle scan request, honoured only in IDLE
//   lo, hi     first / last (inclusive) candidate, latched on accepted start
//   cand       registered candidate driven to the detector input
//   isprime    detector result for cand (same cycle)
//   out_valid  out_data holds a prime awaiting acceptance
//   out_data   prime value
//   out_ready  downstream accept; transfer when out_valid && out_ready
//   count      number of primes found in the current/last scan
//   busy       high from the cycle after an accepted start until DONE exits
//   done       one-cycle pulse at scan end
module prime_scan_ctrl #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   output logic [W-1:0] cand,
   input  logic         isprime,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic [W:0]   count,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

   localparam logic [W-1:0] CAND_ONE = W'(1);
   localparam logic [W:0]   CNT_ONE  = (W+1)'(1);

   state_t       state, state_nxt;
   logic [W-1:0] hi_r, hi_nxt;
   logic [W-1:0] cand_nxt, out_data_nxt;
   logic [W:0]   count_nxt;
   logic         out_valid_nxt, busy_nxt, done_nxt;
   logic         last;

   // ">=" rather than "==": with lo > hi the first candidate already lies
   // past hi_r, so the scan ends after lo instead of wrapping around.
   // For lo <= hi the two forms are equivalent since cand never passes hi_r.
   assign last = (cand >= hi_r);

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cand      <= '0;
         hi_r      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         hi_r      <= hi_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         count     <= count_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = SCAN;
         SCAN: begin
            if (isprime)   state_nxt = HOLD;
            else if (last) state_nxt = DONE;
         end
         HOLD: begin
            if (out_valid && out_ready) state_nxt = last ? DONE : SCAN;
         end
         DONE: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      cand_nxt      = cand;
      hi_nxt        = hi_r;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      count_nxt     = count;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               cand_nxt  = lo;
               hi_nxt    = hi;
               count_nxt = '0;
               busy_nxt  = 1'b1;
            end
         end
         SCAN: begin
            if (isprime) begin
               out_data_nxt  = cand;
               out_valid_nxt = 1'b1;
               count_nxt     = count + CNT_ONE;
            end else if (!last) begin
               cand_nxt = cand + CAND_ONE;
            end
         end
         HOLD: begin
            if (out_valid && out_ready) begin
               out_valid_nxt = 1'b0;
               if (!last) cand_nxt = cand + CAND_ONE;
            end
         end
         DONE: begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
module tb_prime_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] lo, hi;
   logic [3:0] cand;
   logic       isprime;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_ready;
   logic [4:0] count;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int got[$];

   always #5 clk = ~clk;

   // Reference detector: primes below 16
   assign isprime = (cand == 4'd2) || (cand == 4'd3) || (cand == 4'd5) ||
                    (cand == 4'd7) || (cand == 4'd11) || (cand == 4'd13);

   prime_scan_ctrl #(.W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .lo        (lo),
      .hi        (hi),
      .cand      (cand),
      .isprime   (isprime),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Run one scan; expected primes come from exp_q.
   task automatic do_scan(input logic [3:0] l, input logic [3:0] h, input int stall,
                          input int ign_at, input int exp_cnt, input int exp_done_cyc,
                          input string tag);
      bit         seen_done = 0;
      int         done_cyc = -1;
      int         overlap = 0, unstable = 0, range_bad = 0, wait_cnt = 0, extra_done = 0;
      logic [3:0] held = '0;
      logic       busy_at_done = 1'b1;
      got.delete();
      out_ready = (stall == 0);
      lo = l; hi = h; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " busy_after_start"}, busy, 1);
      for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
         if (l <= h) begin
            if (cand < l || cand > h) range_bad++;
         end else if (cand !== l) range_bad++;
         if (done) begin
            seen_done = 1; done_cyc = cyc; busy_at_done = busy;
            if (out_valid) overlap++;
         end
         if (out_valid) begin
            if (wait_cnt == 0) held = out_data;
            else if (out_data !== held) unstable++;
            if (wait_cnt < stall) begin
               out_ready = 1'b0; wait_cnt++;
            end else begin
               out_ready = 1'b1; got.push_back(int'(out_data)); wait_cnt = 0;
            end
         end else begin
            out_ready = (stall == 0);
         end
         if (ign_at >= 0 && cyc == ign_at) begin
            start = 1'b1; lo = 4'd8; hi = 4'd9;
         end else begin
            start = 1'b0;
         end
         if (!seen_done) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      chk({tag, " done_seen"}, seen_done, 1);
      if (exp_done_cyc >= 0) chk({tag, " done_cycle"}, done_cyc, exp_done_cyc);
      chk({tag, " busy_at_done"}, busy_at_done, 0);
      chk({tag, " done_with_valid"}, overlap, 0);
      chk({tag, " data_stable"}, unstable, 0);
      chk({tag, " cand_range"}, range_bad, 0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         if (done) extra_done++;
      end
      chk({tag, " single_done"}, extra_done, 0);
      chk({tag, " count"}, count, exp_cnt);
      chk({tag, " busy_idle"}, busy, 0);
      chk({tag, " valid_idle"}, out_valid, 0);
      chk({tag, " n_primes"}, got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
         chk($sformatf("%s prime[%0d]", tag, k), got[k], exp_q[k]);
      out_ready = 1'b1;
   endtask

   initial begin
      int wait_cyc;
      int late_done;
      reset = 1'b1; start = 1'b0; lo = '0; hi = '0; out_ready = 1'b1;
      #23;
      chk("rst cand", cand, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst count", count, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      exp_q = '{2, 3, 5, 7, 11, 13};
      do_scan(4'd0, 4'd15, 0, -1, 6, -1, "full");

      exp_q = '{2, 3, 5, 7};
      do_scan(4'd2, 4'd7, 5, -1, 4, -1, "backpressure");

      exp_q = '{};
      do_scan(4'd4, 4'd4, 0, -1, 0, 2, "single_np");
      do_scan(4'd9, 4'd3, 0, -1, 0, 2, "lo_gt_hi");

      exp_q = '{13};
      do_scan(4'd13, 4'd1, 0, -1, 1, 3, "lo_gt_hi_prime");

      exp_q = '{};
      do_scan(4'd14, 4'd15, 0, -1, 0, 3, "upper");

      exp_q = '{2, 3, 5, 7, 11, 13};
      do_scan(4'd0, 4'd15, 0, 3, 6, -1, "ignored_start");

      // Stall on prime 5, then reset asynchronously mid-cycle
      out_ready = 1'b0; lo = 4'd4; hi = 4'd15; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_cyc = 0;
      while (!out_valid && wait_cyc < 20) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      chk("hold valid", out_valid, 1);
      chk("hold data", out_data, 5);
      chk("hold count", count, 1);
      #2 reset = 1'b1;
      #1;
      chk("async out_valid", out_valid, 0);
      chk("async busy", busy, 0);
      chk("async count", count, 0);
      chk("async done", done, 0);
      @(posedge clk); #1;
      @(negedge clk); reset = 1'b0;
      late_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (done || out_valid) late_done++;
      end
      chk("post_reset quiet", late_done, 0);
      out_ready = 1'b1;

      exp_q = '{5};
      do_scan(4'd5, 4'd5, 0, -1, 1, 3, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prime_scan_ctrl.md
Name: prime_scan_ctrl

Overview:
- Sequencer that drives the 4-bit combinational prime detector. It sweeps candidate values over a programmed range [lo, hi] and samples the detector's isprime result.
- Each prime found is forwarded on a valid/ready output stream, and a running prime count is kept.
- Sits directly upstream of the detector (feeds its in[3:0]) and directly downstream of it (consumes isprime).

Parameters:
- W, 4, candidate/data width. Fixed to the detector input width; count width is W+1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE
- lo  input  W  first candidate; latched on accepted start
- hi  input  W  last candidate, inclusive; latched on accepted start
- cand  output  W  candidate driven to the detector's in port
- isprime  input  1  detector result for cand, combinational, same cycle
- out_valid  output  1  out_data holds a prime
- out_data  output  W  prime value
- out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high
- count  output  W+1  primes found in current/last scan
- busy  output  1  high from the cycle after an accepted start until DONE exits
- done  output  1  one-cycle pulse at scan end

Behaviour:
- Reset (async assert, release sync to clk): state=IDLE, cand=0, out_valid=0, out_data=0, count=0, busy=0, done=0, hi_r=0.
- All outputs are registered. cand is the registered candidate counter.
- IDLE:
  - When start=1: cand<=lo, hi_r<=hi, count<=0, busy<=1, go to SCAN.
  - When start=0: hold outputs; count retains the last result.
- SCAN (one candidate per cycle, using the isprime value for the current cand):
  - isprime=1: out_data<=cand, out_valid<=1, count<=count+1, go to HOLD.
  - isprime=0 and cand==hi_r: go to DONE.
  - isprime=0 otherwise: cand<=cand+1, stay in SCAN.
- HOLD:
  - out_valid stays high and out_data stays stable until the handshake.
  - On out_valid&&out_ready: out_valid<=0. Then, if cand==hi_r go to DONE; else cand<=cand+1 and go to SCAN.
  - Min 2 cycles per prime; a stalled out_ready stalls the scan indefinitely, with no drop and no overwrite.
- DONE: done<=1 for exactly one cycle, busy<=0, return to IDLE. done must not coincide with out_valid.
- lo>hi: the first candidate is lo. When lo is non-prime, the scan goes SCAN->DONE after 1 cycle. When lo is prime, that single value is emitted, then DONE. The counter never runs past hi_r.
- No wrap: termination compares cand==hi_r before incrementing, so hi=15 never increments cand past 15.
- start while busy (SCAN/HOLD/DONE) is ignored; lo/hi changes during a scan are ignored.
- count max is 2^W; the W+1 width makes overflow impossible.
- Reset mid-scan returns to IDLE immediately: out_valid=0, the pending prime is discarded, count=0, and no done pulse is generated.

Test Plan:
- Full sweep: reset, then start with lo=0, hi=15, out_ready=1, bench detector correct -> out_data sequence 2,3,5,7,11,13; count=6; one done pulse; busy low after.
- Backpressure: lo=2, hi=7, out_ready low for 5 cycles per beat -> out_data=2 is held stable for the whole stall; sequence 2,3,5,7 is lossless; count=4.
- Single/empty: lo=4, hi=4 -> no out_valid, count=0, done 2 cycles after start. lo=9, hi=3 -> same. lo=13, hi=1 -> emits 13, count=1.
- Upper boundary: lo=14, hi=15 -> cand never exceeds 15, no output, done asserted, count=0.
- Ignored start: start pulses during the lo=0, hi=15 scan with lo=8, hi=9 -> the original scan completes unaffected with count=6.
- Async reset while in HOLD (out_data=5 pending) -> out_valid, busy and count go to 0 without waiting for a clk edge; no done. A following start with lo=5, hi=5 emits 5.
